// File: rtl/aes_key_sched_iter.sv
// Iterative AES key expansion: one 32-bit word per cycle from an Nk-deep sliding window,
// round keys streamed in ascending order or, via a 15-entry buffer, in descending order.
module aes_key_sched_iter #(
  parameter int REVERSE_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dec,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

  state_t       state, state_nx;
  logic [31:0]  win [8];
  logic [31:0]  grp [3];
  logic [5:0]   wi;
  logic [5:0]   wtot;
  logic [3:0]   nr;
  logic [2:0]   nk_m1;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic         dec_r;

  logic         accept, xfer, grp_end, stall, gen, in_key;
  logic [5:0]   nk6;
  logic [31:0]  newest, sub_in, sub_out, t, word;
  logic [127:0] grp_full, buf_rd;
  logic [3:0]   rd_idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign accept   = (state == IDLE) && start && (mode != 2'b11);
  assign xfer     = rk_valid && rk_ready;
  assign grp_end  = (wi[1:0] == 2'b11);
  assign stall    = !dec_r && grp_end && rk_valid && !rk_ready;
  assign gen      = (state == EXPAND) && (wi != wtot) && !stall;
  assign nk6      = {3'b000, nk_m1} + 6'd1;
  assign in_key   = (wi < nk6);
  assign newest   = win[nk_m1];
  assign sub_in   = (pos == 3'd0) ? {newest[23:0], newest[31:24]} : newest;
  assign sub_out  = sub_word(sub_in);
  assign t        = (pos == 3'd0) ? (sub_out ^ {rcon, 24'h000000}) :
                    ((nk_m1 == 3'd7) && (pos == 3'd4)) ? sub_out : newest;
  assign word     = in_key ? win[wi[2:0]] : (win[0] ^ t);
  assign grp_full = {grp[0], grp[1], grp[2], word};
  assign rd_idx   = rk_idx - 4'd1;

  // Reverse-order buffer exists only when descending output is enabled
  generate
    if (REVERSE_EN != 0) begin : g_buf
      logic [127:0] rk_buf [15];
      // Store every completed round key of a descending schedule
      always_ff @(posedge clk) begin
        if (gen && grp_end && dec_r) begin
          rk_buf[wi[5:2]] <= grp_full;
        end
      end
      assign buf_rd = rk_buf[rd_idx];
    end else begin : g_nobuf
      assign buf_rd = 128'h0;
    end
  endgenerate

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && (mode != 2'b11)) state_nx = EXPAND;
        else                          state_nx = IDLE;
      end
      EXPAND: begin
        if (dec_r) begin
          if (gen && (wi == wtot - 6'd1)) state_nx = DRAIN;
          else                            state_nx = EXPAND;
        end else begin
          if (xfer && rk_last) state_nx = IDLE;
          else                 state_nx = EXPAND;
        end
      end
      DRAIN: begin
        if (xfer && (rk_idx == 4'd0)) state_nx = IDLE;
        else                          state_nx = DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, word window and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      rk_idx   <= 4'd0;
      rk_data  <= 128'h0;
      wi       <= 6'd0;
      wtot     <= 6'd0;
      nr       <= 4'd0;
      nk_m1    <= 3'd3;
      pos      <= 3'd0;
      rcon     <= 8'h01;
      dec_r    <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      err   <= (state == IDLE) && start && (mode == 2'b11);
      if (accept) begin
        for (int j = 0; j < 8; j++) win[j] <= key[255 - 32*j -: 32];
        wi    <= 6'd0;
        pos   <= 3'd0;
        rcon  <= 8'h01;
        dec_r <= (REVERSE_EN != 0) && dec;
        case (mode)
          2'b00:   begin nk_m1 <= 3'd3; nr <= 4'd10; wtot <= 6'd44; end
          2'b01:   begin nk_m1 <= 3'd5; nr <= 4'd12; wtot <= 6'd52; end
          default: begin nk_m1 <= 3'd7; nr <= 4'd14; wtot <= 6'd60; end
        endcase
      end
      if (gen) begin
        wi  <= wi + 6'd1;
        pos <= (pos == nk_m1) ? 3'd0 : pos + 3'd1;
        if (!in_key) begin
          for (int j = 0; j < 7; j++) win[j] <= (3'(j) == nk_m1) ? word : win[j + 1];
          if (nk_m1 == 3'd7) win[7] <= word;
          if (pos == 3'd0) rcon <= xtime(rcon);
        end
        if (!grp_end) grp[wi[1:0]] <= word;
      end
      // Forward keys go out as each group completes; descending starts from the last group
      if (gen && grp_end && (!dec_r || (wi == wtot - 6'd1))) begin
        rk_valid <= 1'b1;
        rk_data  <= grp_full;
        rk_idx   <= wi[5:2];
        rk_last  <= !dec_r && (wi[5:2] == nr);
      end else if (xfer) begin
        if ((state == DRAIN) && (rk_idx != 4'd0)) begin
          rk_idx  <= rd_idx;
          rk_data <= buf_rd;
          rk_last <= (rk_idx == 4'd1);
        end else begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Self-checking bench for aes_key_sched_iter: known-answer vectors plus random keys,
// modes, order and backpressure, checked against a FIPS-197 word-level model.
module tb_aes_key_sched_iter;

  logic         clk = 1'b0;
  logic         rst, start, dec, rk_ready;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy, rk_valid, rk_last, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  int           total = 0;
  int           bad = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk_exp [15];
  logic [127:0] seen [15];
  logic [255:0] k128, k192, k256, rkey;

  aes_key_sched_iter #(.REVERSE_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dec(dec), .key(key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_idx(rk_idx), .rk_last(rk_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int rotl8(input int v, input int s);
    return ((v << s) | (v >> (8 - s))) & 255;
  endfunction

  // S-box from the generator-3 log walk, independent of any field-inverse formula
  task automatic build_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    sb[0] = 8'h63;
    for (int n = 0; n < 255; n++) begin
      p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 255;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 255;
      if ((q & 'h80) != 0) q = q ^ 'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = 8'(x ^ 'h63);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc [11];
    int nk, nr, r;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nr = nk + 6;
    r = 1;
    for (int j = 1; j <= 10; j++) begin
      rc[j] = 8'(r);
      r = r << 1;
      if (r > 255) r = r ^ 'h11b;
    end
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i <= nr; i++) rk_exp[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endtask

  // Run one schedule from acceptance to final transfer, checking every key against the model
  task automatic run_sched(input logic [1:0] m, input logic d, input logic [255:0] k,
                           input bit bp, input bit timing, input bit poke);
    int nr, n, got, ei;
    bit stalled;
    logic [127:0] held;
    nr = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
    model_expand(m, k);
    for (int i = 0; i < 15; i++) seen[i] = 128'h0;
    start = 1'b1; mode = m; dec = d; key = k; rk_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0; got = 0; stalled = 1'b0; held = 128'h0;
    ei = d ? nr : 0;
    while (got < nr + 1 && n < 400) begin
      if (stalled) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_data", rk_data, held);
      end
      if (n == 2) chk("busy_mid", 128'(busy), 128'(1));
      if (poke && n == 11) chk("poke_err", 128'(err), 128'(0));
      if (poke && n == 10) begin start = 1'b1; key = ~k; mode = 2'b11; end
      else start = 1'b0;
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid && rk_ready) begin
        chk("rk_idx", 128'(rk_idx), 128'(ei));
        chk("rk_data", rk_data, rk_exp[ei]);
        chk("rk_last", 128'(rk_last), 128'(ei == (d ? 0 : nr)));
        if (timing) chk("rk_time", 128'(n), 128'(d ? 4*(nr+1) + (nr - ei) : 4*ei + 4));
        seen[ei] = rk_data;
        got++;
        ei = d ? ei - 1 : ei + 1;
      end
      stalled = rk_valid && !rk_ready;
      held = rk_data;
      step();
      n++;
    end
    start = 1'b0; mode = m; rk_ready = 1'b1;
    chk("key_count", 128'(got), 128'(nr + 1));
    chk("busy_end", 128'(busy), 128'(0));
    chk("valid_end", 128'(rk_valid), 128'(0));
  endtask

  initial begin
    build_sbox();
    rst = 1'b1; start = 1'b0; mode = 2'b00; dec = 1'b0; key = 256'h0; rk_ready = 1'b1;
    step();
    step();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_last", 128'(rk_last), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_data", rk_data, 128'h0);
    rst = 1'b0;
    step();

    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    run_sched(2'b00, 1'b0, k128, 1'b0, 1'b1, 1'b0);
    chk("kat128_r0", seen[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("kat128_r10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    run_sched(2'b01, 1'b0, k192, 1'b0, 1'b1, 1'b1);
    chk("kat192_r12", seen[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_sched(2'b10, 1'b1, k256, 1'b0, 1'b1, 1'b0);
    chk("kat256_r14", seen[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    chk("kat256_r0", seen[0], 128'h000102030405060708090a0b0c0d0e0f);

    rkey = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    run_sched(2'b00, 1'b0, rkey, 1'b1, 1'b0, 1'b0);

    start = 1'b1; mode = 2'b11; key = k128;
    step();
    start = 1'b0;
    chk("err_pulse", 128'(err), 128'(1));
    chk("err_busy", 128'(busy), 128'(0));
    chk("err_valid", 128'(rk_valid), 128'(0));
    step();
    chk("err_clear", 128'(err), 128'(0));
    chk("err_idle", 128'(busy), 128'(0));

    start = 1'b1; mode = 2'b10; dec = 1'b0; key = k256;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    run_sched(2'b00, 1'b0, k128, 1'b0, 1'b1, 1'b0);
    chk("abort_kat_r10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    for (int it = 0; it < 6; it++) begin
      bit bp;
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      bp = 1'($urandom_range(0, 1));
      run_sched(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rkey,
                bp, !bp, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_iter.md
AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

Interface
REQ-001 SHALL have parameter REVERSE_EN, default 1, meaning that 1 instantiates a 15x128 round-key buffer and honours dec, and 0 omits the buffer and treats dec as 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a key schedule; it is accepted on an edge where start=1 and busy=0.
REQ-005 SHALL have port mode, input, 2 bits: key length, 00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled at acceptance.
REQ-006 SHALL have port dec, input, 1 bit: 0 = emit round keys in ascending index order, 1 = emit in descending order; sampled at acceptance.
REQ-007 SHALL have port key, input, 256 bits: cipher key, MSB-aligned; AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses [255:0]; sampled at acceptance.
REQ-008 SHALL have port busy, output, 1 bit: a schedule is in progress.
REQ-009 SHALL have port rk_valid, output, 1 bit: rk_data, rk_idx and rk_last are valid.
REQ-010 SHALL have port rk_ready, input, 1 bit: consumer accepts; a transfer occurs on an edge where rk_valid=1 and rk_ready=1.
REQ-011 SHALL have port rk_data, output, 128 bits: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
REQ-012 SHALL have port rk_idx, output, 4 bits: round index r.
REQ-013 SHALL have port rk_last, output, 1 bit: set on the final key of the schedule.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse when start is accepted with mode=11.

Function
REQ-015 SHALL use Nk=4/6/8 and Nr=10/12/14 for AES-128/192/256, producing 4(Nr+1) words w[i].
REQ-016 SHALL follow FIPS-197 for the words:
  - w[i] = key word i for i<Nk.
  - Otherwise w[i] = w[i-Nk] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0} when i mod Nk=0.
  - t = SubWord(w[i-1]) when Nk=8 and i mod Nk=4.
  - Otherwise t = w[i-1].
REQ-017 SHALL generate exactly one word per non-stalled cycle from an Nk-deep sliding word window, with a combinational 4-byte S-box and Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-018 SHALL implement FSM states IDLE, EXPAND and DRAIN with these transitions:
  - IDLE->EXPAND on valid acceptance.
  - EXPAND->IDLE after the last forward transfer.
  - EXPAND->DRAIN when the last word is written and dec=1.
  - DRAIN->IDLE after the rk_idx=0 transfer.
REQ-019 SHALL, in forward order (dec=0) with rk_ready held at 1:
  - write word i on edge i+1 after acceptance;
  - raise rk_valid for round r after edge 4r+4;
  - present rk_idx 0..Nr in order.
REQ-020 SHALL apply backpressure in forward order: while rk_valid=1 and rk_ready=0, the outputs hold stable, and word generation stalls once the next 4-word group is complete; no key is lost or duplicated.
REQ-021 SHALL, in descending order (dec=1), store all keys, keep rk_valid=0 during EXPAND, then in DRAIN present rk_idx Nr down to 0, at one per cycle while rk_ready=1.
REQ-022 SHALL set rk_last=1 only on rk_idx=Nr in forward order and only on rk_idx=0 in descending order.
REQ-023 SHALL assert busy from the edge after acceptance until the edge on which the final transfer completes.
REQ-024 SHALL ignore start while busy=1, leaving the in-flight schedule unaffected.
REQ-025 SHALL, when start is accepted with mode=11, assert err for one cycle, leave busy=0 and rk_valid=0, and stay in IDLE.
REQ-026 SHALL, with REVERSE_EN=0, behave per forward order regardless of dec and never enter DRAIN.
REQ-027 SHALL allow back-to-back schedules: start is accepted on the edge after busy falls.

Reset
REQ-028 SHALL, when rst=1 at an edge, override all other inputs, abort any schedule, and force IDLE with busy=0, rk_valid=0, rk_last=0, err=0, rk_idx=0 and rk_data=0.
REQ-029 SHALL not require buffer contents to be cleared on reset, but SHALL never present stale buffer contents.

Verification
REQ-030 SHALL pass a forward AES-128 check:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, rk_ready=1;
  - response: rk_idx 0 = 000102030405060708090a0b0c0d0e0f, rk_idx 10 = 13111d7fe3944a17f307a78b4d2b30c5, rk_valid for r=10 after edge 44, rk_last with it.
REQ-031 SHALL pass a forward AES-192 check:
  - stimulus: key 000102..1617;
  - response: rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d.
REQ-032 SHALL pass a descending AES-256 check:
  - stimulus: key 000102..1e1f, dec=1;
  - response: first transfer rk_idx 14 = 24fc79ccbf0979e9371ac23c6d68de36, last transfer rk_idx 0 = 000102..0e0f with rk_last=1.
REQ-033 SHALL pass a backpressure check:
  - stimulus: AES-128 forward with rk_ready toggled randomly;
  - response: identical 11-key sequence, and rk_data stable while stalled.
REQ-034 SHALL pass an error and busy check:
  - stimulus: mode=11;
  - response: one err pulse, busy=0;
  - stimulus: start pulsed mid-schedule;
  - response: ignored.
REQ-035 SHALL pass a reset-abort check:
  - stimulus: rst=1 at edge 20 of an AES-256 schedule, then a new AES-128 start;
  - response: rk_valid=0 and busy=0 the cycle after reset, then the AES-128 vector of REQ-030.
